// File: rtl/free_list_pkg.sv
// Shared types and helpers for the multi-port rename free list.
package free_list_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 7;
  localparam int unsigned DEF_DEPTH      = 128;
  localparam int unsigned DEF_PTR_W      = $clog2(DEF_DEPTH);
  localparam int unsigned DEF_CNT_W      = DEF_PTR_W + 1;
  localparam int unsigned MAX_PORTS      = 4;
  localparam int unsigned PORT_CNT_W     = 3;

  typedef logic [DEF_DATA_WIDTH-1:0] tag_t;

  // Depth is a power of two, so the wrap is a mask.
  function automatic int unsigned ptr_add(int unsigned ptr, int unsigned inc,
                                          int unsigned depth);
    return (ptr + inc) & (depth - 1);
  endfunction

  // Length of the contiguous run of requests, from port 0, that have a tag available.
  function automatic int unsigned prefix_len(logic [MAX_PORTS-1:0] req,
                                             logic [MAX_PORTS-1:0] avail);
    int unsigned len;
    len = 0;
    for (int unsigned k = 0; k < MAX_PORTS; k++) begin
      if (req[k] && avail[k] && len == k) len = k + 1;
    end
    return len;
  endfunction

endpackage

// File: rtl/fl_push_compact.sv
// Prefix popcount: per-port offset among set request bits, plus the total.
module fl_push_compact
  import free_list_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]                 req,
  output logic [N-1:0][PORT_CNT_W-1:0] offset,
  output logic [PORT_CNT_W-1:0]        total
);

  logic [PORT_CNT_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned j = 0; j < N; j++) begin
      offset[j] = acc;
      acc = acc + PORT_CNT_W'(req[j]);
    end
    total = acc;
  end

endmodule

// File: rtl/free_list_mp.sv
// Multi-port circular free list of physical register tags for rename.
// Optional pop-head checkpoint/restore is built when FREE_LIST_CHECKPOINT_EN is defined.
module free_list_mp
  import free_list_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 7,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned PUSH_PORTS = 2,
  parameter int unsigned POP_PORTS  = 2,
  parameter int unsigned INIT_COUNT = 96,
  parameter int unsigned INIT_BASE  = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
`ifdef FREE_LIST_CHECKPOINT_EN
  input  logic                                 ckpt_save,
  input  logic                                 ckpt_restore,
`endif
  input  logic [PUSH_PORTS-1:0]                push,
  input  logic [PUSH_PORTS-1:0][DATA_WIDTH-1:0] push_data,
  output logic                                 ready,
  input  logic [POP_PORTS-1:0]                 pop,
  output logic [POP_PORTS-1:0][DATA_WIDTH-1:0] pop_data,
  output logic [POP_PORTS-1:0]                 valid,
  output logic [$clog2(DEPTH):0]               free_count,
  output logic                                 overflow_err,
  output logic                                 underflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;

  logic [MAX_PORTS-1:0]                  pop_ext, valid_ext;
  logic [POP_PORTS-1:0]                  pop_legal;
  logic [PUSH_PORTS-1:0][PORT_CNT_W-1:0] push_off;
  logic [POP_PORTS-1:0][PORT_CNT_W-1:0]  pop_off;
  logic [PORT_CNT_W-1:0]                 n_push, n_pop, n_pop_eff;
  logic                                  pop_bad;
  int                                    restore_add, cnt_next;
  logic                                  restore_ovf;
  logic                                  unused_pop_off;

`ifdef FREE_LIST_CHECKPOINT_EN
  logic [PTR_W-1:0] ckpt_q, ckpt_d;
`endif

  fl_push_compact #(.N(PUSH_PORTS)) u_push_compact (
    .req    (push),
    .offset (push_off),
    .total  (n_push)
  );

  fl_push_compact #(.N(POP_PORTS)) u_pop_compact (
    .req    (pop_legal),
    .offset (pop_off),
    .total  (n_pop)
  );

  assign unused_pop_off = ^pop_off;

  always_comb begin
    for (int unsigned k = 0; k < POP_PORTS; k++) begin
      valid[k]    = 32'(count_q) > k;
      pop_data[k] = mem_q[PTR_W'(ptr_add(32'(head_q), k, DEPTH))];
    end
  end

  assign ready         = (DEPTH - 32'(count_q)) >= PUSH_PORTS;
  assign free_count    = count_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

  // Only the contiguous prefix of pops backed by valid tags is consumed.
  always_comb begin
    int unsigned len;
    pop_ext   = '0;
    valid_ext = '0;
    pop_ext[POP_PORTS-1:0]   = pop;
    valid_ext[POP_PORTS-1:0] = valid;
    len = prefix_len(pop_ext, valid_ext);
    for (int unsigned k = 0; k < POP_PORTS; k++) pop_legal[k] = k < len;
    pop_bad = |(pop & ~pop_legal);
  end

  always_comb begin
    n_pop_eff   = n_pop;
    restore_add = 0;
    underflow_d = underflow_q | pop_bad;
`ifdef FREE_LIST_CHECKPOINT_EN
    ckpt_d = ckpt_q;
    if (ckpt_restore) begin
      n_pop_eff   = '0;
      underflow_d = underflow_q;
      restore_add = int'(PTR_W'(head_q - ckpt_q));
    end
`endif
    head_d = PTR_W'(ptr_add(32'(head_q), 32'(n_pop_eff), DEPTH));
    tail_d = PTR_W'(ptr_add(32'(tail_q), 32'(n_push), DEPTH));
`ifdef FREE_LIST_CHECKPOINT_EN
    if (ckpt_restore) head_d = ckpt_q;
    else if (ckpt_save) ckpt_d = head_d;
`endif
    cnt_next    = int'(count_q) + int'(n_push) - int'(n_pop_eff) + restore_add;
    restore_ovf = (restore_add != 0) && (cnt_next > int'(DEPTH));
    count_d     = (cnt_next > int'(DEPTH)) ? CNT_W'(DEPTH) : CNT_W'(cnt_next);
    overflow_d  = overflow_q | ((|push) & ~ready) | restore_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= PTR_W'(INIT_COUNT % DEPTH);
      count_q     <= CNT_W'(INIT_COUNT);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i < INIT_COUNT) ? DATA_WIDTH'(INIT_BASE + i) : '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      for (int unsigned j = 0; j < PUSH_PORTS; j++) begin
        if (push[j]) mem_q[PTR_W'(ptr_add(32'(tail_q), 32'(push_off[j]), DEPTH))] <= push_data[j];
      end
    end
  end

`ifdef FREE_LIST_CHECKPOINT_EN
  always_ff @(posedge clk) begin
    if (rst) ckpt_q <= '0;
    else     ckpt_q <= ckpt_d;
  end
`endif

endmodule

// File: tb/tb_free_list_mp.sv
// Directed self-checking bench for free_list_mp (default parameters).
module tb_free_list_mp;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      push, pop;
  logic [1:0][6:0] push_data;
  logic [1:0][6:0] pop_data;
  logic [1:0]      valid;
  logic            ready;
  logic [7:0]      free_count;
  logic            overflow_err, underflow_err;
`ifdef FREE_LIST_CHECKPOINT_EN
  logic            ckpt_save, ckpt_restore;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  free_list_mp dut (
    .clk           (clk),
    .rst           (rst),
`ifdef FREE_LIST_CHECKPOINT_EN
    .ckpt_save     (ckpt_save),
    .ckpt_restore  (ckpt_restore),
`endif
    .push          (push),
    .push_data     (push_data),
    .ready         (ready),
    .pop           (pop),
    .pop_data      (pop_data),
    .valid         (valid),
    .free_count    (free_count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; push = '0; pop = '0; push_data = '0;
`ifdef FREE_LIST_CHECKPOINT_EN
    ckpt_save = 1'b0; ckpt_restore = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid !== 2'b11) begin failures++; $display("FAIL reset_valid: got %b expected 11", valid); end
    checks++; if (pop_data[0] !== 7'd32 || pop_data[1] !== 7'd33) begin
      failures++; $display("FAIL reset_data: got %0d,%0d expected 32,33", pop_data[0], pop_data[1]);
    end
    checks++; if (free_count !== 8'd96) begin failures++; $display("FAIL reset_count: got %0d expected 96", free_count); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      failures++; $display("FAIL reset_err: got %b%b expected 00", overflow_err, underflow_err);
    end
  endtask

  task automatic test_drain_and_empty();
    do_reset();
    for (int c = 0; c < 48; c++) begin
      checks++; if (pop_data[0] !== 7'(32 + 2 * c) || pop_data[1] !== 7'(33 + 2 * c)) begin
        failures++;
        $display("FAIL drain_order c=%0d: got %0d,%0d expected %0d,%0d", c, pop_data[0], pop_data[1],
                 32 + 2 * c, 33 + 2 * c);
      end
      pop = 2'b11; step();
    end
    pop = 2'b00;
    checks++; if (valid !== 2'b00) begin failures++; $display("FAIL empty_valid: got %b expected 00", valid); end
    checks++; if (free_count !== 8'd0) begin failures++; $display("FAIL empty_count: got %0d expected 0", free_count); end
    checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL empty_unf_pre: got %b expected 0", underflow_err); end
    pop = 2'b01; step(); pop = 2'b00;
    checks++; if (underflow_err !== 1'b1) begin failures++; $display("FAIL empty_pop_unf: got %b expected 1", underflow_err); end
    checks++; if (free_count !== 8'd0) begin failures++; $display("FAIL empty_pop_count: got %0d expected 0", free_count); end
    // Push and pop together while empty: no bypass, pop ignored.
    push = 2'b01; push_data[0] = 7'd7; pop = 2'b01; #1;
    checks++; if (valid !== 2'b00) begin failures++; $display("FAIL no_bypass: got %b expected 00", valid); end
    step(); push = 2'b00; pop = 2'b00;
    checks++; if (valid !== 2'b01) begin failures++; $display("FAIL empty_push_valid: got %b expected 01", valid); end
    checks++; if (pop_data[0] !== 7'd7) begin failures++; $display("FAIL empty_push_data: got %0d expected 7", pop_data[0]); end
    checks++; if (free_count !== 8'd1) begin failures++; $display("FAIL empty_push_count: got %0d expected 1", free_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      push = 2'b11; push_data[0] = 7'(2 * c); push_data[1] = 7'(2 * c + 1); step();
    end
    push = 2'b00;
    checks++; if (free_count !== 8'd126) begin failures++; $display("FAIL fill_count: got %0d expected 126", free_count); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL fill_ready: got %b expected 1", ready); end
    push = 2'b11; push_data[0] = 7'd10; push_data[1] = 7'd11; step(); push = 2'b00;
    checks++; if (free_count !== 8'd128) begin failures++; $display("FAIL full_count: got %0d expected 128", free_count); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %b expected 0", ready); end
    checks++; if (valid !== 2'b11) begin failures++; $display("FAIL full_valid: got %b expected 11", valid); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL full_ovf_pre: got %b expected 0", overflow_err); end
    push = 2'b01; push_data[0] = 7'd5; step(); push = 2'b00;
    checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", overflow_err); end
    checks++; if (free_count !== 8'd128) begin failures++; $display("FAIL ovf_sat: got %0d expected 128", free_count); end
  endtask

  task automatic test_wrap();
    int exp;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      push = 2'b11; push_data[0] = 7'(2 * c); push_data[1] = 7'(2 * c + 1); step();
    end
    push = 2'b00;
    checks++; if (free_count !== 8'd128 || ready !== 1'b0) begin
      failures++; $display("FAIL wrap_full: got count=%0d ready=%b expected 128,0", free_count, ready);
    end
    for (int c = 0; c < 64; c++) begin
      exp = (c < 48) ? 32 + 2 * c : 2 * (c - 48);
      checks++; if (pop_data[0] !== 7'(exp) || pop_data[1] !== 7'(exp + 1)) begin
        failures++;
        $display("FAIL wrap_order c=%0d: got %0d,%0d expected %0d,%0d", c, pop_data[0], pop_data[1],
                 exp, exp + 1);
      end
      pop = 2'b11; step();
    end
    pop = 2'b00;
    checks++; if (free_count !== 8'd0 || overflow_err !== 1'b0) begin
      failures++; $display("FAIL wrap_end: got count=%0d ovf=%b expected 0,0", free_count, overflow_err);
    end
  endtask

  task automatic test_bad_prefix();
    do_reset();
    for (int c = 0; c < 45; c++) begin pop = 2'b11; step(); end
    pop = 2'b01; step(); pop = 2'b00;
    checks++; if (free_count !== 8'd5 || pop_data[0] !== 7'd123) begin
      failures++; $display("FAIL prefix_setup: got count=%0d data=%0d expected 5,123", free_count, pop_data[0]);
    end
    checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL prefix_unf_pre: got %b expected 0", underflow_err); end
    pop = 2'b10; step(); pop = 2'b00;
    checks++; if (underflow_err !== 1'b1) begin failures++; $display("FAIL prefix_unf: got %b expected 1", underflow_err); end
    checks++; if (free_count !== 8'd5) begin failures++; $display("FAIL prefix_count: got %0d expected 5", free_count); end
    checks++; if (pop_data[0] !== 7'd123 || pop_data[1] !== 7'd124) begin
      failures++; $display("FAIL prefix_head: got %0d,%0d expected 123,124", pop_data[0], pop_data[1]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push = 2'b11; push_data[0] = 7'd1; push_data[1] = 7'd2; pop = 2'b11; step();
    checks++; if (free_count !== 8'd96 || pop_data[0] !== 7'd34) begin
      failures++; $display("FAIL b2b_1: got count=%0d data=%0d expected 96,34", free_count, pop_data[0]);
    end
    push = 2'b10; push_data[1] = 7'd3; pop = 2'b11; step();
    push = 2'b00; pop = 2'b00;
    checks++; if (free_count !== 8'd95 || pop_data[0] !== 7'd36) begin
      failures++; $display("FAIL b2b_2: got count=%0d data=%0d expected 95,36", free_count, pop_data[0]);
    end
    checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      failures++; $display("FAIL b2b_err: got %b%b expected 00", overflow_err, underflow_err);
    end
  endtask

`ifdef FREE_LIST_CHECKPOINT_EN
  task automatic test_checkpoint();
    do_reset();
    for (int c = 0; c < 5; c++) begin pop = 2'b11; step(); end
    pop = 2'b00;
    ckpt_save = 1'b1; step(); ckpt_save = 1'b0;
    for (int c = 0; c < 3; c++) begin pop = 2'b11; step(); end
    pop = 2'b00;
    checks++; if (free_count !== 8'd80 || pop_data[0] !== 7'd48) begin
      failures++; $display("FAIL ckpt_pre: got count=%0d data=%0d expected 80,48", free_count, pop_data[0]);
    end
    ckpt_restore = 1'b1; push = 2'b01; push_data[0] = 7'd3; pop = 2'b11; step();
    ckpt_restore = 1'b0; push = 2'b00; pop = 2'b00;
    checks++; if (pop_data[0] !== 7'd42) begin failures++; $display("FAIL ckpt_head: got %0d expected 42", pop_data[0]); end
    checks++; if (free_count !== 8'd87) begin failures++; $display("FAIL ckpt_count: got %0d expected 87", free_count); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL ckpt_ovf: got %b expected 0", overflow_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_drain_and_empty();
    test_overflow();
    test_wrap();
    test_bad_prefix();
    test_back_to_back();
`ifdef FREE_LIST_CHECKPOINT_EN
    test_checkpoint();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
